// File: rtl/sdp_ram.sv
// sdp_ram: simple-dual-port synchronous RAM (one write port, one read port, one clock).
// Byte-lane write strobes, one-cycle read-valid pulse, write-first collision forwarding,
// and a self-clear sequencer that zeroes every word after each reset.
// Optional macro OUT_REG_EN adds an output register stage (read latency 2 instead of 1).
module sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       ren,
  input  logic [ADDR_WIDTH-1:0]      raddr,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       rvalid,
  output logic                       busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rvalid_q, rvalid_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [STRB_WIDTH-1:0]   mem_strb;

  logic                    waddr_ok;
  logic                    raddr_ok;
  logic                    collide;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   fwd_word;

  // Addresses at or beyond DEPTH never reach the array, so there is no aliasing.
  assign waddr_ok = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_W);
  assign collide  = wen && waddr_ok && (waddr == raddr);

  // Sequencer: sweep zeros through every word after reset, then hand the port to the user.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_addr  = waddr;
    mem_wdata = din;
    mem_strb  = wstrb;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        mem_strb  = '1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        mem_we = wen && waddr_ok;
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Read path: write-first merge of new bytes over the stored word on an address match.
  always_comb begin
    rd_word  = raddr_ok ? mem[raddr] : '0;
    fwd_word = rd_word;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (collide && wstrb[i]) begin
        fwd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
    dout_d   = dout_q;
    rvalid_d = 1'b0;
    if (state_q == ST_CLEAR) begin
      dout_d = '0;
    end else if (ren) begin
      rvalid_d = 1'b1;
      dout_d   = raddr_ok ? fwd_word : '0;
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage array with per-byte write enables.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the clear sequencer zeroes it, keeping it mappable to RAM.
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (mem_strb[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign busy = busy_q;

`ifdef OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout_pipe_q;
  logic                  rvalid_pipe_q;

  // Extra output stage: data and valid travel together, adding one cycle of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_pipe_q   <= '0;
      rvalid_pipe_q <= 1'b0;
    end else begin
      dout_pipe_q   <= dout_q;
      rvalid_pipe_q <= rvalid_q;
    end
  end

  assign dout   = dout_pipe_q;
  assign rvalid = rvalid_pipe_q;
`else
  assign dout   = dout_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sdp_ram.sv
// tb_sdp_ram: directed-vector bench for sdp_ram. Two instances share all inputs:
// DEPTH=16 (full address space) and DEPTH=12 (out-of-range address handling).
module tb_sdp_ram;

`ifdef OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        wen;
  logic [3:0]  waddr;
  logic [3:0]  wstrb;
  logic [31:0] din;
  logic        ren;
  logic [3:0]  raddr;

  logic [31:0] dout16, dout12;
  logic        rvalid16, rvalid12;
  logic        busy16, busy12;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  bb_addr [3];
  logic [31:0] bb_exp  [3];

  sdp_ram #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wstrb(wstrb), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout16), .rvalid(rvalid16), .busy(busy16)
  );

  sdp_ram #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wstrb(wstrb), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout12), .rvalid(rvalid12), .busy(busy12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; din = d; wstrb = s;
    tick();
    wen = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a,
                         input logic [31:0] e16, input logic [31:0] e12);
    ren = 1'b1; raddr = a;
    tick();
    ren = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_rv16"},   32'(rvalid16), 32'd1);
    check({tag, "_dout16"}, dout16, e16);
    check({tag, "_rv12"},   32'(rvalid12), 32'd1);
    check({tag, "_dout12"}, dout12, e12);
  endtask

  task automatic do_collide(input string tag, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] e);
    wen = 1'b1; waddr = a; din = d; wstrb = s;
    ren = 1'b1; raddr = a;
    tick();
    wen = 1'b0; ren = 1'b0;
    repeat (LAT - 1) tick();
    check({tag, "_rv16"},   32'(rvalid16), 32'd1);
    check({tag, "_dout16"}, dout16, e);
    check({tag, "_dout12"}, dout12, e);
  endtask

  // Release reset and count busy cycles; requests issued during the clear must be ignored.
  task automatic clear_phase(input string tag);
    int c16, c12, rv;
    c16 = 0; c12 = 0; rv = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (busy16) c16++;
      if (busy12) c12++;
      if (rvalid16 || rvalid12) rv++;
      wen = (k < 10); ren = (k < 10);
      waddr = 4'd2; raddr = 4'd2; din = 32'hFFFF_FFFF; wstrb = 4'hF;
      tick();
    end
    wen = 1'b0; ren = 1'b0;
    check({tag, "_busy_cycles16"}, 32'(c16), 32'd16);
    check({tag, "_busy_cycles12"}, 32'(c12), 32'd12);
    check({tag, "_rvalid_while_busy"}, 32'(rv), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      do_read($sformatf("%s_zero_a%0d", tag, a), 4'(a), 32'h0, 32'h0);
    end
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_busy16"},   32'(busy16),   32'd1);
    check({tag, "_busy12"},   32'(busy12),   32'd1);
    check({tag, "_rvalid16"}, 32'(rvalid16), 32'd0);
    check({tag, "_rvalid12"}, 32'(rvalid12), 32'd0);
    check({tag, "_dout16"},   dout16,        32'h0);
    check({tag, "_dout12"},   dout12,        32'h0);
  endtask

  initial begin
    rst_n = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wstrb = '0; din = '0;
    #3 rst_n = 1'b0;
    repeat (3) tick();

    // Reset state, then the power-on clear.
    check_in_reset("rst1");
    clear_phase("clr1");
    check_all_zero("clr1");

    // Full write then read, and hold/drop behaviour afterwards.
    do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
    do_read("wr_full", 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    tick();
    check("rvalid_drop16", 32'(rvalid16), 32'd0);
    check("dout_hold16",   dout16, 32'hDEAD_BEEF);

    // Partial write: lanes 0 and 2 only.
    do_write(4'd3, 32'h1122_3344, 4'b0101);
    do_read("wr_part", 4'd3, 32'hDE22_BE44, 32'hDE22_BE44);

    // Collisions: full and partial, then read back what was stored.
    do_collide("coll_full", 4'd7, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D);
    do_collide("coll_part", 4'd3, 32'h5566_7788, 4'b1010, 32'h5522_7744);
    do_read("coll_back", 4'd3, 32'h5522_7744, 32'h5522_7744);

    // Zero strobe is a no-op.
    do_write(4'd7, 32'h0000_0000, 4'h0);
    do_read("strb_zero", 4'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Back-to-back reads with rvalid held continuously.
    bb_addr[0] = 4'd3; bb_exp[0] = 32'h5522_7744;
    bb_addr[1] = 4'd7; bb_exp[1] = 32'hCAFE_F00D;
    bb_addr[2] = 4'd1; bb_exp[2] = 32'h0000_0000;
    for (int k = 0; k < LAT + 3; k++) begin
      int j;
      ren = (k < 3);
      if (k < 3) raddr = bb_addr[k];
      tick();
      j = k - LAT + 1;
      if (j >= 0 && j < 3) begin
        check($sformatf("b2b_rv_%0d", j),   32'(rvalid16), 32'd1);
        check($sformatf("b2b_dout_%0d", j), dout16, bb_exp[j]);
      end else if (j >= 3) begin
        check("b2b_rv_end", 32'(rvalid16), 32'd0);
      end
    end
    ren = 1'b0;

    // Out-of-range write on the 12-word instance: dropped, no aliasing onto word 1.
    do_write(4'd13, 32'hFFFF_FFFF, 4'hF);
    do_read("oob_13", 4'd13, 32'hFFFF_FFFF, 32'h0);
    do_read("oob_alias1", 4'd1, 32'h0, 32'h0);
    do_read("oob_15", 4'd15, 32'h0, 32'h0);

    // Reset in RUN, then reset again with the clear pointer at 5.
    rst_n = 1'b0;
    tick();
    check_in_reset("rst_run");
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check_in_reset("rst_mid");
    clear_phase("clr2");
    check_all_zero("clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
